// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read responder.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StLoad,
        StData,
        StIgnore
    } state_e;

    localparam logic [7:0] OPC_READ      = 8'h03;
    localparam logic [7:0] OPC_FAST_READ = 8'h0B;

    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 24;
    localparam int unsigned DATA_BITS  = 32;
    localparam int unsigned DUMMY_BITS = 8;
    localparam int unsigned CNT_W      = 6;

    // Lowest-address byte moves to the top so it is shifted out first.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_sck_edge.sv
// SCK edge and chip-select detection; SCK is synchronous to clock, so no synchronizers.
module spi_sck_edge (
    input  logic clock,
    input  logic reset,
    input  logic spi_sck,
    input  logic spi_ss,
    output logic rise,
    output logic fall,
    output logic ss_active,
    output logic ss_end
);

    logic sck_q;
    logic ss_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_q <= 1'b0;
            ss_q  <= 1'b1;
        end else begin
            sck_q <= spi_sck;
            ss_q  <= spi_ss;
        end
    end

    assign rise      = spi_sck & ~sck_q;
    assign fall      = ~spi_sck & sck_q;
    assign ss_active = ~spi_ss;
    assign ss_end    = spi_ss & ~ss_q;

endmodule

// File: rtl/spi_flash_resp.sv
// SPI flash responder: READ (0x03) with auto-incrementing word fetches, mode 0.
// Define SPI_FLASH_FAST_READ_EN to also accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_resp
    import spi_flash_pkg::*;
#(
    parameter int unsigned MEM_AW   = 22,
    parameter logic [7:0]  CMD_READ = OPC_READ
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata
);

    logic rise;
    logic fall;
    logic ss_active;
    logic ss_end;

    spi_sck_edge u_edge (
        .clock     (clock),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .rise      (rise),
        .fall      (fall),
        .ss_active (ss_active),
        .ss_end    (ss_end)
    );

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-2:0]   rx_q, rx_d;
    logic [DATA_BITS-2:0]   tx_q, tx_d;
    logic [MEM_AW-1:0]      raddr_q, raddr_d;
    logic                   miso_q, miso_d;
    logic                   skip_q, skip_d;
    logic                   fast_q, fast_d;
    logic                   ren;
    logic                   op_fast;
    logic [CMD_BITS-1:0]    opcode;
    logic [DATA_BITS-1:0]   word;

    assign opcode = {rx_q[CMD_BITS-2:0], spi_mosi};
    assign word   = byte_swap(mem_rdata);

`ifdef SPI_FLASH_FAST_READ_EN
    assign op_fast = (opcode == OPC_FAST_READ);
`else
    assign op_fast = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        raddr_d = raddr_q;
        miso_d  = miso_q;
        skip_d  = skip_q;
        fast_d  = fast_q;
        ren     = 1'b0;

        if (state_q != StIdle && (ss_end || !ss_active)) begin
            state_d = StIdle;
            cnt_d   = '0;
            miso_d  = 1'b1;
            skip_d  = 1'b0;
            fast_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    miso_d = 1'b1;
                    if (ss_active) begin
                        state_d = StCmd;
                        cnt_d   = '0;
                    end
                end
                StCmd: begin
                    if (rise) begin
                        rx_d = {rx_q[ADDR_BITS-3:0], spi_mosi};
                        if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                            cnt_d   = '0;
                            fast_d  = op_fast;
                            state_d = (opcode == CMD_READ || op_fast) ? StAddr : StIgnore;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StAddr: begin
                    if (rise) begin
                        rx_d = {rx_q[ADDR_BITS-3:0], spi_mosi};
                        if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                            // rx_q holds address bits [23:1]; byte offset bits are dropped.
                            cnt_d   = '0;
                            raddr_d = MEM_AW'(rx_q[ADDR_BITS-2:1]);
                            if (fast_q) begin
                                state_d = StDummy;
                            end else begin
                                ren     = 1'b1;
                                skip_d  = 1'b1;
                                state_d = StLoad;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StDummy: begin
                    if (rise) begin
                        if (cnt_q == CNT_W'(DUMMY_BITS - 1)) begin
                            cnt_d   = '0;
                            ren     = 1'b1;
                            skip_d  = 1'b1;
                            state_d = StLoad;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StLoad: begin
                    miso_d  = word[DATA_BITS-1];
                    tx_d    = word[DATA_BITS-2:0];
                    cnt_d   = '0;
                    state_d = StData;
                end
                StData: begin
                    if (fall) begin
                        // The fall closing the last address/dummy clock must not advance
                        // past bit 0, which the master has not sampled yet.
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            ren     = 1'b1;
                            raddr_d = raddr_q + MEM_AW'(1);
                            state_d = StLoad;
                        end else begin
                            miso_d = tx_q[DATA_BITS-2];
                            tx_d   = {tx_q[DATA_BITS-3:0], 1'b0};
                            cnt_d  = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StIgnore: begin
                    miso_d = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            raddr_q <= '0;
            miso_q  <= 1'b1;
            skip_q  <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            raddr_q <= raddr_d;
            miso_q  <= miso_d;
            skip_q  <= skip_d;
            fast_q  <= fast_d;
        end
    end

    assign spi_miso  = miso_q;
    assign mem_ren   = ren & ~reset;
    assign mem_raddr = raddr_d;

endmodule
